// File: rtl/rom_ctrl_gen_if.sv
// Host-side register interface of the ROM controller: three one-cycle command
// strobes, the byte the host writes, and the byte/flag the host reads back.
interface rom_ctrl_gen_if;
  logic       wr_addr;    // shift wr_buffer into the ROM address
  logic       wr_data;    // start a write cycle of wr_buffer
  logic       rd_data;    // start a read cycle
  logic [7:0] wr_buffer;  // host write byte
  logic [7:0] rd_buffer;  // last byte read from the ROM
  logic       busy;       // a read or write cycle is in progress

  // Command strobes are single-cycle pulses with no ready/ack: the host may only
  // expect one to act when busy=0 in the cycle it is sampled; strobes presented
  // while busy=1 are dropped. Results (rd_buffer, address) are valid once busy=0.
  modport master (
    output wr_addr, wr_data, rd_data, wr_buffer,
    input  rd_buffer, busy
  );

  modport slave (
    input  wr_addr, wr_data, rd_data, wr_buffer,
    output rd_buffer, busy
  );
endinterface

// File: rtl/rom_ctrl_gen.sv
// Parallel flash/ROM bus controller: byte-serial address load, timed read and
// write cycles with programmable setup/strobe/hold lengths, optional address
// post-increment. Every ROM pin comes straight from a flop.
module rom_ctrl_gen #(
  parameter int AW      = 19,
  parameter int T_RD    = 4,
  parameter int T_SETUP = 1,
  parameter int T_WR    = 3,
  parameter int T_HOLD  = 1,
  parameter int AUTOINC = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  rom_ctrl_gen_if.slave       host,
  output logic [AW-1:0]       rom_a,
  inout  wire  [7:0]          rom_d,
  output logic                rom_cs_n,
  output logic                rom_oe_n,
  output logic                rom_we_n,
  output logic [2:0]          state_o
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_STROBE = 3'd1,
    S_RD_END    = 3'd2,
    S_WR_SETUP  = 3'd3,
    S_WR_STROBE = 3'd4,
    S_WR_HOLD   = 3'd5
  } state_t;

  localparam int CW = 16;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [7:0]      rdbuf_q, rdbuf_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            busy_q, busy_d;
  logic            cs_n_q, cs_n_d;
  logic            oe_n_q, oe_n_d;
  logic            we_n_q, we_n_d;
  logic            drv_q, drv_d;

  // Next state, cycle counter, address/data registers; pin levels are decoded
  // from the next state so the registered pins change on the state edge.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdbuf_d = rdbuf_q;
    wdata_d = wdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (host.wr_addr) begin
          addr_d = {addr_q[AW-9:0], host.wr_buffer};
        end else if (host.wr_data) begin
          wdata_d = host.wr_buffer;
          state_d = S_WR_SETUP;
          cnt_d   = CW'(T_SETUP - 1);
        end else if (host.rd_data) begin
          state_d = S_RD_STROBE;
          cnt_d   = CW'(T_RD - 1);
        end
      end
      S_RD_STROBE: begin
        if (cnt_q == '0) begin
          rdbuf_d = rom_d;
          state_d = S_RD_END;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RD_END: begin
        state_d = S_IDLE;
        if (AUTOINC != 0) addr_d = addr_q + AW'(1);
      end
      S_WR_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_WR_STROBE;
          cnt_d   = CW'(T_WR - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_WR_HOLD;
          cnt_d   = CW'(T_HOLD - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WR_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          if (AUTOINC != 0) addr_d = addr_q + AW'(1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
    cs_n_d = !((state_d == S_RD_STROBE) || (state_d == S_WR_SETUP) ||
               (state_d == S_WR_STROBE) || (state_d == S_WR_HOLD));
    oe_n_d = (state_d != S_RD_STROBE);
    we_n_d = (state_d != S_WR_STROBE);
    drv_d  = (state_d == S_WR_SETUP) || (state_d == S_WR_STROBE) ||
             (state_d == S_WR_HOLD);
  end

  // State and pin registers; reset aborts any cycle without incrementing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdbuf_q <= 8'hFF;
      wdata_q <= 8'h00;
      busy_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      drv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdbuf_q <= rdbuf_d;
      wdata_q <= wdata_d;
      busy_q  <= busy_d;
      cs_n_q  <= cs_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      drv_q   <= drv_d;
    end
  end

  assign rom_d          = drv_q ? wdata_q : 8'hzz;
  assign rom_a          = addr_q;
  assign rom_cs_n       = cs_n_q;
  assign rom_oe_n       = oe_n_q;
  assign rom_we_n       = we_n_q;
  assign host.busy      = busy_q;
  assign host.rd_buffer = rdbuf_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_rom_ctrl_gen.sv
// Bench for rom_ctrl_gen: dut0 uses the default timing, dut1 uses AUTOINC=0,
// T_RD=1 and a stretched write. Each DUT talks to a small ROM model; dut0 is
// checked by a scoreboard fed from a high-level model of address/memory state.
module tb_rom_ctrl_gen;
  localparam int AW0 = 19;
  localparam int AW1 = 12;
  localparam int MASK0 = (1 << AW0) - 1;
  localparam int MASK1 = (1 << AW1) - 1;
  localparam int T_RD = 4, T_SETUP = 1, T_WR = 3, T_HOLD = 1;
  localparam int EW = 65;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  rom_ctrl_gen_if h0();
  rom_ctrl_gen_if h1();

  logic [AW0-1:0] a0;
  logic [AW1-1:0] a1;
  wire  [7:0]     d0, d1;
  logic cs0, oe0, we0, cs1, oe1, we1;
  logic [2:0] st0, st1;

  rom_ctrl_gen #(.AW(AW0), .T_RD(T_RD), .T_SETUP(T_SETUP), .T_WR(T_WR),
                 .T_HOLD(T_HOLD), .AUTOINC(1)) dut0 (
    .clk(clk), .rst_n(rst_n), .host(h0), .rom_a(a0), .rom_d(d0),
    .rom_cs_n(cs0), .rom_oe_n(oe0), .rom_we_n(we0), .state_o(st0));

  rom_ctrl_gen #(.AW(AW1), .T_RD(1), .T_SETUP(2), .T_WR(1),
                 .T_HOLD(2), .AUTOINC(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .host(h1), .rom_a(a1), .rom_d(d1),
    .rom_cs_n(cs1), .rom_oe_n(oe1), .rom_we_n(we1), .state_o(st1));

  // ---------------- ROM models ----------------
  function automatic logic [7:0] rom_default(input int a);
    return 8'((a * 37) ^ (a >> 5) ^ 8'h3C);
  endfunction

  logic [7:0] rom0_mem [int];
  logic [7:0] rom1_mem [int];
  int rom0_ver = 0, rom1_ver = 0;
  logic [7:0] rom0_q, rom1_q;
  logic probe_en = 1'b0;

  always @(a0 or rom0_ver)
    rom0_q = rom0_mem.exists(int'(a0)) ? rom0_mem[int'(a0)] : rom_default(int'(a0));
  always @(a1 or rom1_ver)
    rom1_q = rom1_mem.exists(int'(a1)) ? rom1_mem[int'(a1)] : rom_default(int'(a1));

  assign d0 = (cs0 === 1'b0 && oe0 === 1'b0) ? rom0_q :
              probe_en ? 8'hA5 : 8'hzz;
  assign d1 = (cs1 === 1'b0 && oe1 === 1'b0) ? rom1_q : 8'hzz;

  always @(posedge we0) if (cs0 === 1'b0) begin rom0_mem[int'(a0)] = d0; rom0_ver++; end
  always @(posedge we1) if (cs1 === 1'b0) begin rom1_mem[int'(a1)] = d1; rom1_ver++; end

  // ---------------- scoreboard ----------------
  int n_cmp = 0, n_bad = 0;
  logic [EW-1:0] exp_q[$];
  logic [7:0] ref0_mem [int];
  int model_addr0 = 0;
  logic [7:0] model_rdb0 = 8'hFF;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  function automatic logic [EW-1:0] pack(input logic k, input logic [7:0] d,
      input logic [7:0] rdb, input int addr, input int bl, input int sl);
    return {k, d, rdb, 32'(addr), 8'(bl), 8'(sl)};
  endfunction

  function automatic logic [7:0] ref_read0(input int a);
    return ref0_mem.exists(a) ? ref0_mem[a] : rom_default(a);
  endfunction

  // Monitor: measures each dut0 busy window and checks it against the queue.
  int mon_cyc, mon_oe, mon_we, mon_dbad, mon_amove;
  logic [AW0-1:0] mon_a_start;
  logic mon_prev = 1'b0;
  logic [EW-1:0] mon_e;
  int both_low = 0, idle_bad = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      mon_prev = 1'b0;
    end else begin
      if (oe0 === 1'b0 && we0 === 1'b0) both_low++;
      if (oe1 === 1'b0 && we1 === 1'b0) both_low++;
      if (h0.busy === 1'b0 && !(cs0 === 1'b1 && oe0 === 1'b1 && we0 === 1'b1)) idle_bad++;
      if (h1.busy === 1'b0 && !(cs1 === 1'b1 && oe1 === 1'b1 && we1 === 1'b1)) idle_bad++;
      if (h0.busy === 1'b1) begin
        if (!mon_prev) begin
          mon_cyc = 0; mon_oe = 0; mon_we = 0; mon_dbad = 0; mon_amove = 0;
          mon_a_start = a0;
        end
        mon_cyc++;
        if (oe0 === 1'b0) mon_oe++;
        if (we0 === 1'b0) mon_we++;
        if (a0 !== mon_a_start) mon_amove++;
        if (exp_q.size() > 0 && exp_q[0][64] && d0 !== exp_q[0][63:56]) mon_dbad++;
      end else if (mon_prev) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_cycle");
        end else begin
          mon_e = exp_q.pop_front();
          chk("busy_len", 64'(mon_cyc), 64'(mon_e[15:8]));
          chk("strobe_len", 64'(mon_e[64] ? mon_we : mon_oe), 64'(mon_e[7:0]));
          chk("other_strobe", 64'(mon_e[64] ? mon_oe : mon_we), 64'd0);
          chk("rd_buffer", 64'(h0.rd_buffer), 64'(mon_e[55:48]));
          chk("rom_a", 64'(a0), 64'(mon_e[47:16]));
          chk("addr_stable", 64'(mon_amove), 64'd0);
          if (mon_e[64]) chk("wr_data_drive", 64'(mon_dbad), 64'd0);
        end
      end
      mon_prev = h0.busy;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input int sel, input logic wa, input logic wd, input logic rd,
                       input logic [7:0] b);
    @(posedge clk); #1;
    if (sel == 0) begin
      h0.wr_addr = wa; h0.wr_data = wd; h0.rd_data = rd; h0.wr_buffer = b;
    end else begin
      h1.wr_addr = wa; h1.wr_data = wd; h1.rd_data = rd; h1.wr_buffer = b;
    end
    @(posedge clk); #1;
    h0.wr_addr = 1'b0; h0.wr_data = 1'b0; h0.rd_data = 1'b0;
    h1.wr_addr = 1'b0; h1.wr_data = 1'b0; h1.rd_data = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    if (exp_q.size() != 0) begin
      fail_now("drain_timeout");
      exp_q.delete();
    end
  endtask

  // One host operation on dut0; the model applies the strobe priority.
  task automatic op0(input logic wa, input logic wd, input logic rd, input logic [7:0] b);
    int nxt;
    logic [7:0] rdb;
    if (wa) begin
      model_addr0 = ((model_addr0 << 8) | int'(b)) & MASK0;
      pulse(0, wa, wd, rd, b);
      for (int k = 0; k < 2; k++) begin
        @(negedge clk);
        chk("addr_load_busy", 64'(h0.busy), 64'd0);
      end
      chk("addr_load", 64'(a0), 64'(model_addr0));
    end else begin
      nxt = (model_addr0 + 1) & MASK0;
      if (wd) begin
        ref0_mem[model_addr0] = b;
        exp_q.push_back(pack(1'b1, b, model_rdb0, nxt, T_SETUP + T_WR + T_HOLD, T_WR));
      end else begin
        rdb = ref_read0(model_addr0);
        exp_q.push_back(pack(1'b0, 8'h00, rdb, nxt, T_RD + 1, T_RD));
        model_rdb0 = rdb;
      end
      model_addr0 = nxt;
      pulse(0, wa, wd, rd, b);
      drain();
    end
  endtask

  task automatic load0(input int a);
    op0(1'b1, 1'b0, 1'b0, 8'((a >> 16) & 255));
    op0(1'b1, 1'b0, 1'b0, 8'((a >> 8) & 255));
    op0(1'b1, 1'b0, 1'b0, 8'(a & 255));
  endtask

  // One command on dut1, measuring the busy window directly.
  task automatic cyc1(input logic wd, input logic [7:0] b,
                      output int busy_c, output int oe_c, output int we_c, output int dbad);
    busy_c = 0; oe_c = 0; we_c = 0; dbad = 0;
    pulse(1, 1'b0, wd, !wd, b);
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (h1.busy !== 1'b1) break;
      busy_c++;
      if (oe1 === 1'b0) oe_c++;
      if (we1 === 1'b0) we_c++;
      if (wd && d1 !== b) dbad++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int bc, oc, wc, db, r, model_addr1;
    logic [7:0] rb;
    logic wa, wd, rd;
    h0.wr_addr = 0; h0.wr_data = 0; h0.rd_data = 0; h0.wr_buffer = 0;
    h1.wr_addr = 0; h1.wr_data = 0; h1.rd_data = 0; h1.wr_buffer = 0;
    rom0_mem[32'h7ABCD] = 8'h5A; ref0_mem[32'h7ABCD] = 8'h5A; rom0_ver++;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_rom_a", 64'(a0), 64'd0);
    chk("rst_rd_buffer", 64'(h0.rd_buffer), 64'hFF);
    chk("rst_busy", 64'(h0.busy), 64'd0);
    chk("rst_pins", 64'({cs0, oe0, we0}), 64'h7);

    // Reset in the middle of a write aborts it.
    load0(32'h12345);
    pulse(0, 1'b0, 1'b1, 1'b0, 8'hC3);
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk);
    probe_en = 1'b1;
    @(negedge clk);
    chk("rstw_pins", 64'({cs0, oe0, we0}), 64'h7);
    chk("rstw_rom_d_released", 64'(d0), 64'hA5);
    chk("rstw_rom_a", 64'(a0), 64'd0);
    chk("rstw_rd_buffer", 64'(h0.rd_buffer), 64'hFF);
    chk("rstw_busy", 64'(h0.busy), 64'd0);
    probe_en = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    model_addr0 = 0; model_rdb0 = 8'hFF;

    // Address load, MSB first, upper bits shift out.
    op0(1'b1, 1'b0, 1'b0, 8'h07);
    op0(1'b1, 1'b0, 1'b0, 8'hAB);
    op0(1'b1, 1'b0, 1'b0, 8'hCD);
    chk("t2_addr", 64'(a0), 64'h7ABCD);
    op0(1'b1, 1'b0, 1'b0, 8'h12);
    chk("t2_addr_shift", 64'(a0), 64'h3CD12);

    // Read 5A, then write C3 at the incremented address.
    load0(32'h7ABCD);
    op0(1'b0, 1'b0, 1'b1, 8'h00);
    chk("t3_rd_buffer", 64'(h0.rd_buffer), 64'h5A);
    chk("t3_rom_a", 64'(a0), 64'h7ABCE);
    op0(1'b0, 1'b1, 1'b0, 8'hC3);
    chk("t4_rom_a", 64'(a0), 64'h7ABCF);
    chk("t4_rom_store", 64'(rom0_mem.exists(32'h7ABCE) ? rom0_mem[32'h7ABCE] : 8'h00), 64'hC3);
    load0(32'h7ABCE);
    op0(1'b0, 1'b0, 1'b1, 8'h00);

    // Wrap at all-ones, with strobes pulsed mid-cycle that must be ignored.
    load0(32'h7FFFF);
    exp_q.push_back(pack(1'b0, 8'h00, ref_read0(model_addr0), 0, T_RD + 1, T_RD));
    model_rdb0 = ref_read0(model_addr0);
    model_addr0 = 0;
    pulse(0, 1'b0, 1'b0, 1'b1, 8'h00);
    pulse(0, 1'b1, 1'b0, 1'b1, 8'hAA);
    drain();
    chk("t5_wrap", 64'(a0), 64'd0);

    // Priority: address shift beats read; write beats read.
    op0(1'b1, 1'b0, 1'b1, 8'h21);
    op0(1'b0, 1'b1, 1'b1, 8'h6E);

    // Randomized traffic around a few addresses so writes get read back.
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2) begin
        load0(32'h100 + $urandom_range(0, 3));
      end else begin
        wa = ($urandom_range(0, 5) == 0);
        wd = 1'($urandom_range(0, 1));
        rd = 1'($urandom_range(0, 1));
        if (!wa && !wd) rd = 1'b1;
        op0(wa, wd, rd, 8'($urandom));
      end
    end

    // dut1: AUTOINC=0, one-cycle read, stretched write.
    model_addr1 = 0;
    pulse(1, 1'b1, 1'b0, 1'b0, 8'h0A);
    model_addr1 = ((model_addr1 << 8) | 32'h0A) & MASK1;
    pulse(1, 1'b1, 1'b1, 1'b1, 8'h37);
    model_addr1 = ((model_addr1 << 8) | 32'h37) & MASK1;
    @(negedge clk);
    chk("d1_busy_after_prio", 64'(h1.busy), 64'd0);
    chk("d1_addr", 64'(a1), 64'(model_addr1));
    rb = rom_default(model_addr1);
    cyc1(1'b0, 8'h00, bc, oc, wc, db);
    chk("d1_rd_busy", 64'(bc), 64'd2);
    chk("d1_rd_oe", 64'(oc), 64'd1);
    chk("d1_rd_we", 64'(wc), 64'd0);
    chk("d1_rd_buffer", 64'(h1.rd_buffer), 64'(rb));
    chk("d1_rd_addr_held", 64'(a1), 64'(model_addr1));
    cyc1(1'b1, 8'h9C, bc, oc, wc, db);
    chk("d1_wr_busy", 64'(bc), 64'd5);
    chk("d1_wr_we", 64'(wc), 64'd1);
    chk("d1_wr_oe", 64'(oc), 64'd0);
    chk("d1_wr_drive", 64'(db), 64'd0);
    chk("d1_wr_addr_held", 64'(a1), 64'(model_addr1));
    cyc1(1'b0, 8'h00, bc, oc, wc, db);
    chk("d1_readback", 64'(h1.rd_buffer), 64'h9C);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("oe_we_overlap", 64'(both_low), 64'd0);
    chk("idle_pins", 64'(idle_bad), 64'd0);
    foreach (ref0_mem[k])
      chk("rom_content", rom0_mem.exists(k) ? 64'(rom0_mem[k]) : 64'hDEAD, 64'(ref0_mem[k]));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
